mrd_tag_alloc_arb: RTL and testbench

//  Shared MRd tag allocator and round-robin arbiter for all S2C scatter-gather channels.

---
 rtl/mrd_tag_alloc_arb_if.sv | 27 ++
 rtl/mrd_tag_alloc_arb.sv | 116 +++++++++++
 tb/tb_mrd_tag_alloc_arb.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/mrd_tag_alloc_arb_if.sv
// Request/grant and tag-release bundle between the S2C channels, the RC completion demux
// and the shared MRd tag allocator. The master side drives requests and releases.
interface mrd_tag_alloc_arb_if #(
    parameter int NUM_CHAN = 4,
    parameter int NUM_TAGS = 32,
    parameter int CNT_W    = $clog2(NUM_TAGS + 1)
);
    logic                sys_ena;
    logic [NUM_CHAN-1:0] alloc_tag_req;
    logic [NUM_CHAN-1:0] allocated_tag_rdy;
    logic [7:0]          allocated_tag;
    logic                tag_release_valid;
    logic [7:0]          tag_release_tag;
    logic [CNT_W-1:0]    tags_in_use;
    logic                pool_empty;
    logic                release_err;

    modport master (
        output sys_ena, alloc_tag_req, tag_release_valid, tag_release_tag,
        input  allocated_tag_rdy, allocated_tag, tags_in_use, pool_empty, release_err
    );

    modport slave (
        input  sys_ena, alloc_tag_req, tag_release_valid, tag_release_tag,
        output allocated_tag_rdy, allocated_tag, tags_in_use, pool_empty, release_err
    );
endinterface

// File: rtl/mrd_tag_alloc_arb.sv
// Shared MRd tag allocator: round-robin grant of one channel per cycle, handing out the
// lowest free tag of a bitmap pool; tags return to the pool on last-completion release.
module mrd_tag_alloc_arb #(
    parameter int NUM_CHAN = 4,
    parameter int NUM_TAGS = 32,
    parameter int CNT_W    = $clog2(NUM_TAGS + 1)
) (
    input  logic               s_axi_clk,
    input  logic               s_axi_rstn,
    mrd_tag_alloc_arb_if.slave bus
);
    localparam int PTR_W = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1;

    logic [NUM_TAGS-1:0]   busy_q, busy_d;
    logic [PTR_W-1:0]      rr_q, rr_d;
    logic [NUM_CHAN-1:0]   rdy_q, rdy_d;
    logic [7:0]            tag_q, tag_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  empty_q, empty_d;
    logic                  err_q, err_d;

    logic [NUM_CHAN-1:0]   eligible;
    logic [2*NUM_CHAN-1:0] elig_rot;
    logic                  win_found;
    int                    win_idx;
    logic                  free_found;
    logic [7:0]            free_tag;
    logic [NUM_TAGS-1:0]   free_oh;
    logic [NUM_TAGS-1:0]   rel_clr;
    logic                  rel_ok;
    logic                  grant;

    // The channel granted last cycle still holds req, so it is masked for one cycle.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        eligible  = bus.alloc_tag_req & ~rdy_q;
        elig_rot  = {eligible, eligible} >> rr_q;
        win_found = 1'b0;
        win_idx   = 0;
        for (int k = NUM_CHAN - 1; k >= 0; k--) begin
            if (elig_rot[k]) begin
                win_found = 1'b1;
                win_idx   = (int'(rr_q) + k) % NUM_CHAN;
            end
        end
    end

    always_comb begin
        free_found = 1'b0;
        free_tag   = 8'd0;
        free_oh    = '0;
        for (int t = NUM_TAGS - 1; t >= 0; t--) begin
            if (!busy_q[t]) begin
                free_found = 1'b1;
                free_tag   = 8'(t);
                free_oh    = '0;
                free_oh[t] = 1'b1;
            end
        end
    end

    // Release is legal only for an in-range tag that is currently busy.
    always_comb begin
        rel_clr = '0;
        for (int t = 0; t < NUM_TAGS; t++) begin
            rel_clr[t] = bus.tag_release_valid && (bus.tag_release_tag == 8'(t)) && busy_q[t];
        end
        rel_ok = |rel_clr;
    end

    always_comb begin
        grant   = bus.sys_ena & win_found & free_found;
        busy_d  = (busy_q & ~rel_clr) | (grant ? free_oh : '0);
        cnt_d   = cnt_q + CNT_W'(grant) - CNT_W'(rel_ok);
        empty_d = &busy_d;
        err_d   = bus.tag_release_valid & ~rel_ok;
        rr_d    = rr_q;
        rdy_d   = '0;
        tag_d   = tag_q;
        if (grant) begin
            rr_d  = PTR_W'((win_idx + 1) % NUM_CHAN);
            tag_d = free_tag;
            for (int c = 0; c < NUM_CHAN; c++) begin
                rdy_d[c] = (win_idx == c);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge s_axi_clk) begin
        if (!s_axi_rstn) begin
            // NOTE: the bitmap is a flop vector, not RAM, so clearing it on reset is cheap and forgets outstanding tags.
            busy_q  <= '0;
            rr_q    <= '0;
            rdy_q   <= '0;
            tag_q   <= 8'd0;
            cnt_q   <= '0;
            empty_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            busy_q  <= busy_d;
            rr_q    <= rr_d;
            rdy_q   <= rdy_d;
            tag_q   <= tag_d;
            cnt_q   <= cnt_d;
            empty_q <= empty_d;
            err_q   <= err_d;
        end
    end

    assign bus.allocated_tag_rdy = rdy_q;
    assign bus.allocated_tag     = tag_q;
    assign bus.tags_in_use       = cnt_q;
    assign bus.pool_empty        = empty_q;
    assign bus.release_err       = err_q;
endmodule

// File: tb/tb_mrd_tag_alloc_arb.sv
// Directed bench for mrd_tag_alloc_arb: a 32-tag instance driven from a vector table and
// a 4-tag instance exercised by a hand-written pool-exhaustion sequence.
module tb_mrd_tag_alloc_arb;
    logic clk = 1'b0;
    logic rstn32;
    logic rstn4;

    always #5 clk = ~clk;

    mrd_tag_alloc_arb_if #(.NUM_CHAN(4), .NUM_TAGS(32)) if32 ();
    mrd_tag_alloc_arb_if #(.NUM_CHAN(4), .NUM_TAGS(4))  if4  ();

    mrd_tag_alloc_arb #(.NUM_CHAN(4), .NUM_TAGS(32)) u_dut32 (
        .s_axi_clk  (clk),
        .s_axi_rstn (rstn32),
        .bus        (if32)
    );

    mrd_tag_alloc_arb #(.NUM_CHAN(4), .NUM_TAGS(4)) u_dut4 (
        .s_axi_clk  (clk),
        .s_axi_rstn (rstn4),
        .bus        (if4)
    );

    typedef struct {
        bit         rstn;
        bit         ena;
        logic [3:0] req;
        bit         rel_v;
        logic [7:0] rel_tag;
        logic [3:0] exp_rdy;
        logic [7:0] exp_tag;
        int         exp_cnt;
        bit         exp_empty;
        bit         exp_err;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add_vec(input bit rstn, input bit ena, input logic [3:0] req,
                           input bit rel_v, input logic [7:0] rel_tag,
                           input logic [3:0] exp_rdy, input logic [7:0] exp_tag,
                           input int exp_cnt, input bit exp_empty, input bit exp_err);
        vec_t v;
        v.rstn = rstn;       v.ena = ena;         v.req = req;
        v.rel_v = rel_v;     v.rel_tag = rel_tag;
        v.exp_rdy = exp_rdy; v.exp_tag = exp_tag; v.exp_cnt = exp_cnt;
        v.exp_empty = exp_empty; v.exp_err = exp_err;
        vecs.push_back(v);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] oh;
        int         lat;

        rstn32 = 1'b0;
        rstn4  = 1'b0;
        if32.sys_ena = 1'b1; if32.alloc_tag_req = '0; if32.tag_release_valid = 1'b0; if32.tag_release_tag = '0;
        if4.sys_ena  = 1'b1; if4.alloc_tag_req  = '0; if4.tag_release_valid  = 1'b0; if4.tag_release_tag  = '0;

        // rstn ena req     rv tag | rdy     tag cnt emp err
        add_vec(0, 1, 4'b0000, 0, 0,  4'b0000, 0, 0,  0, 0);  // 0 reset state
        add_vec(1, 1, 4'b0100, 0, 0,  4'b0100, 0, 1,  0, 0);  // 1 uncontended grant ch2
        add_vec(1, 1, 4'b0000, 0, 0,  4'b0000, 0, 1,  0, 0);
        add_vec(0, 1, 4'b0000, 0, 0,  4'b0000, 0, 0,  0, 0);  // 3 reset, rr back to 0
        add_vec(1, 1, 4'b1111, 0, 0,  4'b0001, 0, 1,  0, 0);  // 4..8 round robin
        add_vec(1, 1, 4'b1111, 0, 0,  4'b0010, 1, 2,  0, 0);
        add_vec(1, 1, 4'b1111, 0, 0,  4'b0100, 2, 3,  0, 0);
        add_vec(1, 1, 4'b1111, 0, 0,  4'b1000, 3, 4,  0, 0);
        add_vec(1, 1, 4'b1111, 0, 0,  4'b0001, 4, 5,  0, 0);
        add_vec(0, 1, 4'b0000, 0, 0,  4'b0000, 0, 0,  0, 0);  // 9 reset
        add_vec(1, 1, 4'b1111, 0, 0,  4'b0001, 0, 1,  0, 0);
        add_vec(1, 1, 4'b1111, 0, 0,  4'b0010, 1, 2,  0, 0);
        add_vec(1, 1, 4'b1111, 0, 0,  4'b0100, 2, 3,  0, 0);
        add_vec(1, 1, 4'b0001, 1, 0,  4'b0001, 3, 3,  0, 0);  // 13 release 0 + grant: pre-edge bitmap gives 3
        add_vec(1, 1, 4'b0000, 0, 0,  4'b0000, 0, 3,  0, 0);
        add_vec(1, 1, 4'b0010, 0, 0,  4'b0010, 0, 4,  0, 0);  // 15 freed tag 0 now grantable
        add_vec(1, 1, 4'b0000, 0, 0,  4'b0000, 0, 4,  0, 0);
        add_vec(1, 1, 4'b0000, 1, 40, 4'b0000, 0, 4,  0, 1);  // 17 out-of-range release
        add_vec(1, 1, 4'b0000, 1, 5,  4'b0000, 0, 4,  0, 1);  // 18 release of free tag
        add_vec(1, 1, 4'b0000, 0, 0,  4'b0000, 0, 4,  0, 0);
        add_vec(1, 1, 4'b0000, 1, 2,  4'b0000, 0, 3,  0, 0);  // 20 legal release
        add_vec(1, 1, 4'b1111, 0, 0,  4'b0100, 2, 4,  0, 0);  // 21..27 fill to 10 busy
        add_vec(1, 1, 4'b1111, 0, 0,  4'b1000, 4, 5,  0, 0);
        add_vec(1, 1, 4'b1111, 0, 0,  4'b0001, 5, 6,  0, 0);
        add_vec(1, 1, 4'b1111, 0, 0,  4'b0010, 6, 7,  0, 0);
        add_vec(1, 1, 4'b1111, 0, 0,  4'b0100, 7, 8,  0, 0);
        add_vec(1, 1, 4'b1111, 0, 0,  4'b1000, 8, 9,  0, 0);
        add_vec(1, 1, 4'b1111, 0, 0,  4'b0001, 9, 10, 0, 0);
        add_vec(0, 0, 4'b0001, 0, 0,  4'b0000, 0, 0,  0, 0);  // 28 mid-operation reset
        add_vec(1, 0, 4'b0001, 0, 0,  4'b0000, 0, 0,  0, 0);  // 29..30 disabled
        add_vec(1, 0, 4'b0001, 0, 0,  4'b0000, 0, 0,  0, 0);
        add_vec(1, 1, 4'b0001, 0, 0,  4'b0001, 0, 1,  0, 0);  // 31 enabled: grant next cycle
        add_vec(1, 1, 4'b0001, 0, 0,  4'b0000, 0, 1,  0, 0);  // 32 same channel masked
        add_vec(1, 1, 4'b0001, 0, 0,  4'b0001, 1, 2,  0, 0);
        add_vec(1, 0, 4'b0000, 1, 0,  4'b0000, 0, 1,  0, 0);  // 34 release while disabled
        add_vec(1, 0, 4'b0001, 0, 0,  4'b0000, 0, 1,  0, 0);
        add_vec(1, 1, 4'b0001, 1, 1,  4'b0001, 0, 1,  0, 0);  // 36 grant + release, count holds
        add_vec(1, 1, 4'b0000, 0, 0,  4'b0000, 0, 1,  0, 0);

        foreach (vecs[i]) begin
            rstn32                 = vecs[i].rstn;
            if32.sys_ena           = vecs[i].ena;
            if32.alloc_tag_req     = vecs[i].req;
            if32.tag_release_valid = vecs[i].rel_v;
            if32.tag_release_tag   = vecs[i].rel_tag;
            step();
            check($sformatf("v%0d rdy", i), 32'(if32.allocated_tag_rdy), 32'(vecs[i].exp_rdy));
            if (vecs[i].exp_rdy != 4'b0000 || !vecs[i].rstn)
                check($sformatf("v%0d tag", i), 32'(if32.allocated_tag), 32'(vecs[i].exp_tag));
            check($sformatf("v%0d tags_in_use", i), 32'(if32.tags_in_use), vecs[i].exp_cnt);
            check($sformatf("v%0d pool_empty", i), 32'(if32.pool_empty), 32'(vecs[i].exp_empty));
            check($sformatf("v%0d release_err", i), 32'(if32.release_err), 32'(vecs[i].exp_err));
        end
        if32.alloc_tag_req     = '0;
        if32.tag_release_valid = 1'b0;

        // Pool exhaustion on the 4-tag instance.
        step();
        check("x reset rdy", 32'(if4.allocated_tag_rdy), 32'd0);
        check("x reset cnt", 32'(if4.tags_in_use), 32'd0);
        check("x reset empty", 32'(if4.pool_empty), 32'd0);
        rstn4 = 1'b1;
        if4.alloc_tag_req = 4'b1111;
        for (int g = 0; g < 4; g++) begin
            step();
            oh = 4'b0001 << g;
            check($sformatf("x fill%0d rdy", g), 32'(if4.allocated_tag_rdy), 32'(oh));
            check($sformatf("x fill%0d tag", g), 32'(if4.allocated_tag), g);
            check($sformatf("x fill%0d cnt", g), 32'(if4.tags_in_use), g + 1);
            check($sformatf("x fill%0d empty", g), 32'(if4.pool_empty), (g == 3) ? 32'd1 : 32'd0);
        end
        if4.alloc_tag_req = 4'b0010;
        for (int w = 0; w < 2; w++) begin
            step();
            check($sformatf("x wait%0d rdy", w), 32'(if4.allocated_tag_rdy), 32'd0);
            check($sformatf("x wait%0d empty", w), 32'(if4.pool_empty), 32'd1);
            check($sformatf("x wait%0d cnt", w), 32'(if4.tags_in_use), 32'd4);
        end
        if4.tag_release_valid = 1'b1;
        if4.tag_release_tag   = 8'd2;
        step();
        if4.tag_release_valid = 1'b0;
        check("x rel rdy", 32'(if4.allocated_tag_rdy), 32'd0);
        check("x rel cnt", 32'(if4.tags_in_use), 32'd3);
        check("x rel empty", 32'(if4.pool_empty), 32'd0);
        lat = 1;
        while (if4.allocated_tag_rdy == 4'b0000 && lat < 6) begin
            step();
            lat++;
        end
        check("x regrant latency", lat, 32'd2);
        check("x regrant rdy", 32'(if4.allocated_tag_rdy), 32'b0010);
        check("x regrant tag", 32'(if4.allocated_tag), 32'd2);
        check("x regrant cnt", 32'(if4.tags_in_use), 32'd4);
        check("x regrant empty", 32'(if4.pool_empty), 32'd1);
        if4.alloc_tag_req = 4'b0000;
        step();
        check("x idle rdy", 32'(if4.allocated_tag_rdy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
